mux8_rr_arbiter: RTL

- Round-robin arbiter that shares the 8:1 single-bit select datapath between 8 requesters.
- Each requester i owns data bit i; the winner's index drives the 3-bit select, and the selected bit is presented on y.
- Sits between the requesting agents and the 8:1 select datapath.
- Handles fairness, hold-until-release ownership and a maximum-hold timeout.

---
 rtl/mux8_rr_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/mux8_rr_arbiter.sv
// rtl/mux8_rr_arbiter.sv - round-robin arbiter owning an 8:1 single-bit select datapath
// Grant is held until the owner releases or the hold limit expires; re-arbitration has no idle bubble.
module mux8_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic [7:0] i,
  output logic [7:0] gnt,
  output logic [2:0] s,
  output logic       busy,
  output logic       new_gnt,
  output logic       y
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  localparam bit         HOLD_LIMITED = (MAX_HOLD != 0);
  localparam logic [7:0] HOLD_LAST    = (MAX_HOLD == 0) ? 8'd0 : 8'(MAX_HOLD - 1);

  state_t     state_q;
  logic [7:0] gnt_q;
  logic [2:0] s_q;
  logic [2:0] last_q;
  logic       busy_q;
  logic       new_gnt_q;
  logic [7:0] hold_cnt_q;
  logic [7:0] hold_cnt_d;

  logic       any_req;
  logic       release_c;
  logic [2:0] scan_base;
  logic [2:0] winner;

  function automatic logic [2:0] rr_pick(input logic [7:0] r, input logic [2:0] start);
    logic [2:0] idx;
    logic       found;
    rr_pick = start;
    found   = 1'b0;
    for (int k = 0; k < 8; k++) begin
      idx = start + 3'(k);
      if (!found && r[idx]) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction

  // On release last becomes s, so scanning from s+1 while granted equals scanning from last+1.
  always_comb begin
    any_req    = |req;
    scan_base  = (state_q == GRANT) ? s_q + 3'd1 : last_q + 3'd1;
    winner     = rr_pick(req, scan_base);
    release_c  = !req[s_q] || (HOLD_LIMITED && (hold_cnt_q == HOLD_LAST));
    hold_cnt_d = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gnt_q      <= 8'h00;
      s_q        <= 3'd0;
      last_q     <= 3'd7;
      busy_q     <= 1'b0;
      new_gnt_q  <= 1'b0;
      hold_cnt_q <= 8'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_req) begin
            state_q    <= GRANT;
            s_q        <= winner;
            gnt_q      <= 8'b1 << winner;
            busy_q     <= 1'b1;
            new_gnt_q  <= 1'b1;
            hold_cnt_q <= 8'd0;
          end else begin
            gnt_q      <= 8'h00;
            s_q        <= 3'd0;
            busy_q     <= 1'b0;
            new_gnt_q  <= 1'b0;
            hold_cnt_q <= 8'd0;
          end
        end
        GRANT: begin
          if (release_c) begin
            last_q <= s_q;
            if (any_req) begin
              s_q        <= winner;
              gnt_q      <= 8'b1 << winner;
              busy_q     <= 1'b1;
              new_gnt_q  <= 1'b1;
              hold_cnt_q <= 8'd0;
            end else begin
              state_q    <= IDLE;
              gnt_q      <= 8'h00;
              s_q        <= 3'd0;
              busy_q     <= 1'b0;
              new_gnt_q  <= 1'b0;
              hold_cnt_q <= 8'd0;
            end
          end else begin
            new_gnt_q  <= 1'b0;
            hold_cnt_q <= hold_cnt_d;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign gnt     = gnt_q;
  assign s       = s_q;
  assign busy    = busy_q;
  assign new_gnt = new_gnt_q;
  assign y       = busy_q & i[s_q];

endmodule
